// File: rtl/alu_inst_encoder.sv
// Encodes ALU operation requests into RV32I OP-IMM / OP instruction words and
// buffers them in a small FIFO with valid/ready handshakes on both sides.
module alu_inst_encoder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  alu_sel,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [11:0] imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Inst,
    output logic        err,
    output logic [15:0] enc_count
);
    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; valid never waits on ready, and ready depends only on registered state.
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP_REG = 7'b0110011;

    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          rdy_en;
    logic          legal;
    logic [31:0]   enc_word;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic          accept;
    logic          push;
    logic          pop;

    always_comb begin
        legal    = 1'b1;
        funct3   = 3'b000;
        funct7   = 7'b0000000;
        enc_word = 32'h0;
        case (alu_sel)
            5'd0:  funct3 = 3'b000;
            5'd1:  funct3 = 3'b010;
            5'd2:  funct3 = 3'b011;
            5'd3:  funct3 = 3'b100;
            5'd4:  funct3 = 3'b110;
            5'd5:  funct3 = 3'b111;
            5'd6:  funct3 = 3'b001;
            5'd7:  funct3 = 3'b101;
            5'd8:  begin funct3 = 3'b101; funct7 = 7'b0100000; end
            5'd9:  funct3 = 3'b000;
            5'd10: begin funct3 = 3'b000; funct7 = 7'b0100000; end
            5'd11: funct3 = 3'b001;
            5'd12: funct3 = 3'b010;
            5'd13: funct3 = 3'b011;
            5'd14: funct3 = 3'b100;
            5'd15: funct3 = 3'b101;
            5'd16: begin funct3 = 3'b101; funct7 = 7'b0100000; end
            5'd17: funct3 = 3'b110;
            5'd18: funct3 = 3'b111;
            default: legal = 1'b0;
        endcase
        if (alu_sel <= 5'd5) begin
            enc_word = {imm, rs1, funct3, rd, OP_IMM};
        end else if (alu_sel <= 5'd8) begin
            // Shift immediates only carry a 5-bit shamt; upper bits must be clear.
            if (imm[11:5] != 7'b0) legal = 1'b0;
            enc_word = {funct7, imm[4:0], rs1, funct3, rd, OP_IMM};
        end else begin
            enc_word = {funct7, rs2, rs1, funct3, rd, OP_REG};
        end
    end

    assign in_ready  = rdy_en && (count != FULL_CNT);
    assign out_valid = (count != '0);
    assign Inst      = out_valid ? mem[rd_ptr] : 32'h0;
    assign accept    = in_valid && in_ready;
    assign push      = accept && legal;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= enc_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            rdy_en    <= 1'b0;
            err       <= 1'b0;
            enc_count <= 16'h0;
        end else begin
            rdy_en <= 1'b1;
            err    <= accept && !legal;
            if (push) begin
                wr_ptr    <= wr_ptr + AW'(1);
                enc_count <= enc_count + 16'd1;
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule
